dma_timing_ctrl: RTL
====================

DMA_TIMING_CTRL -- requirements
Module: dma_timing_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 CLK  in  1  system clock; all state changes on rising edge.
REQ-003 RESET  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  unmasked, polarity-resolved request from the priority logic.
REQ-005 req_ch  in  2  granted channel number, valid with req_valid.
REQ-006 dreq_active  in  1  granted channel's DREQ still asserted (polarity resolved).
REQ-007 xfer_type  in  2  00 verify, 01 write (IO->mem), 10 read (mem->IO), 11 treated as verify.
REQ-008 xfer_mode  in  2  00 demand, 01 single, 10 block, 11 treated as single.
REQ-009 HLDA  in  1  bus grant from CPU.
REQ-010 READY  in  1  memory/IO ready; low inserts wait states.
REQ-011 EOP_N_in  in  1  external end-of-process, active-low.
REQ-012 tc  in  1  current word count is terminal (last transfer).
REQ-013 HRQ  out  1  hold request to CPU.
REQ-014 AEN  out  1  address enable.
REQ-015 ADSTB  out  1  address strobe.
REQ-016 DACK  out  4  one-hot internal active-high acknowledge; polarity applied downstream.
REQ-017 MEMR_N, MEMW_N, IOR_N, IOW_N  out  1 each  active-low bus strobes.
REQ-018 upd  out  1  one-cycle pulse: increment/decrement address, decrement count.
REQ-019 EOP_N_out  out  1  internal end-of-process, active-low.
REQ-020 done  out  1  one-cycle completion pulse; done_ch  out  2  channel that completed.

Function
REQ-021 FSM states SI, S0, S1, S2, S3, SW, S4; all outputs registered.
REQ-022 SI: HRQ=0; on req_valid, latch req_ch, xfer_type, xfer_mode; go to S0; HRQ=1 on the next cycle.
REQ-023 S0: hold HRQ=1; on HLDA=1 go to S1; otherwise stay.
REQ-024 S1: AEN=1 and ADSTB=1 for exactly one cycle; go to S2.
REQ-025 S2: DACK[ch]=1; read strobe low (IOR_N for write, MEMR_N for read, none for verify); go to S3.
REQ-026 S3: write strobe low (MEMW_N for write, IOW_N for read); READY=0 -> SW; READY=1 -> S4.
REQ-027 SW: hold all strobes and DACK; READY=1 -> S4; no timeout.
REQ-028 S4: deassert strobes; upd=1; AEN and DACK held through S4.
REQ-029 S4 termination: if tc=1 or latched EOP, then EOP_N_out=0 for one cycle, done=1, done_ch=ch, HRQ=0, go to SI.
REQ-030 S4 continuation by mode: single -> SI with HRQ dropped; block -> S1; demand -> S1 if dreq_active, else SI with done=0.
REQ-031 EOP_N_in low during S2/S3/SW SHALL be latched and take effect at S4; the latch clears in SI.
REQ-032 HLDA=0 in S1/S2/S3/SW SHALL abort to SI next cycle: all outputs idle, no upd, no done.
REQ-033 req_valid and req_ch SHALL be ignored outside SI; the channel cannot change mid-service.
REQ-034 tc and EOP active together SHALL produce a single EOP_N_out pulse and a single done pulse.

Reset
REQ-035 RESET SHALL force SI: HRQ=AEN=ADSTB=0, DACK=0000, all strobes=1, EOP_N_out=1, upd=done=0, done_ch=00, EOP latch clear; reset in any state takes effect on the next edge.

Structure
REQ-036 State enum, xfer_type and xfer_mode encodings SHALL live in DmaPackage; no sub-module required.

Verification
REQ-037 Single write, ch2, READY=1, HLDA 2 cycles after HRQ -> IOR_N then MEMW_N low, one upd, HRQ drops after S4, done=0.
REQ-038 Block read, ch1, tc at 3rd S4 -> 3 upd pulses, MEMR_N/IOW_N each 3 times, EOP_N_out and done once, done_ch=01.
REQ-039 READY low 4 cycles in S3 -> exactly 4 SW cycles, strobes held low, then S4.
REQ-040 Demand ch0, dreq_active falls after 2nd transfer -> 2 upd pulses, return to SI, HRQ=0, no done.
REQ-041 HLDA dropped in S2 -> SI next cycle, DACK=0000, no upd; RESET asserted in SW -> all outputs at reset values next edge.

Source files
------------

// File: rtl/dma_timing_ctrl_pkg.sv
// DMA timing controller shared types.
// State, transfer encodings and bus output bundle.
package DmaPackage;

  typedef enum logic [2:0] {
    SI, S0, S1, S2, S3, SW, S4
  } dmaState_t;

  typedef enum logic [1:0] {
    XferVerify = 2'b00,
    XferWrite  = 2'b01,
    XferRead   = 2'b10
  } xferType_t;

  typedef enum logic [1:0] {
    ModeDemand = 2'b00,
    ModeSingle = 2'b01,
    ModeBlock  = 2'b10
  } xferMode_t;

  typedef struct packed {
    logic memrN;
    logic memwN;
    logic iorN;
    logic iowN;
  } strobes_t;

  typedef struct packed {
    logic     hrq;
    logic     aen;
    logic     adstb;
    logic [3:0] dack;
    strobes_t stb;
    logic     upd;
    logic     eopN;
    logic     done;
  } busOut_t;

  localparam strobes_t StbIdle = '{
    memrN: 1'b1, memwN: 1'b1,
    iorN: 1'b1, iowN: 1'b1
  };

  localparam busOut_t IdleOut = '{
    hrq: 1'b0, aen: 1'b0,
    adstb: 1'b0, dack: 4'b0000,
    stb: StbIdle, upd: 1'b0,
    eopN: 1'b1, done: 1'b0
  };

  function automatic xferType_t normType(
    input logic [1:0] t
  );
    xferType_t r;
    case (t)
      2'b01:   r = XferWrite;
      2'b10:   r = XferRead;
      default: r = XferVerify;
    endcase
    return r;
  endfunction

  // The unused mode code falls back to single-transfer behaviour.
  function automatic xferMode_t normMode(
    input logic [1:0] m
  );
    xferMode_t r;
    case (m)
      2'b00:   r = ModeDemand;
      2'b10:   r = ModeBlock;
      default: r = ModeSingle;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] chOneHot(
    input logic [1:0] ch
  );
    return 4'b0001 << ch;
  endfunction

  function automatic strobes_t rdStb(
    input xferType_t t
  );
    strobes_t s;
    s = StbIdle;
    case (t)
      XferWrite: s.iorN = 1'b0;
      XferRead:  s.memrN = 1'b0;
      default:   s = StbIdle;
    endcase
    return s;
  endfunction

  function automatic strobes_t wrStb(
    input xferType_t t
  );
    strobes_t s;
    s = StbIdle;
    case (t)
      XferWrite: s.memwN = 1'b0;
      XferRead:  s.iowN = 1'b0;
      default:   s = StbIdle;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dma_timing_ctrl_if.sv
// DMA timing controller request / bus interface.
// master: controller side, slave: priority logic, CPU and bus side.
interface dma_timing_ctrl_if;

  logic       req_valid;
  logic [1:0] req_ch;
  logic       dreq_active;
  logic [1:0] xfer_type;
  logic [1:0] xfer_mode;
  logic       HLDA;
  logic       READY;
  logic       EOP_N_in;
  logic       tc;

  logic       HRQ;
  logic       AEN;
  logic       ADSTB;
  logic [3:0] DACK;
  logic       MEMR_N;
  logic       MEMW_N;
  logic       IOR_N;
  logic       IOW_N;
  logic       upd;
  logic       EOP_N_out;
  logic       done;
  logic [1:0] done_ch;

  modport master (
    input  req_valid, req_ch,
    input  dreq_active,
    input  xfer_type, xfer_mode,
    input  HLDA, READY,
    input  EOP_N_in, tc,
    output HRQ, AEN, ADSTB, DACK,
    output MEMR_N, MEMW_N,
    output IOR_N, IOW_N,
    output upd, EOP_N_out,
    output done, done_ch
  );

  modport slave (
    output req_valid, req_ch,
    output dreq_active,
    output xfer_type, xfer_mode,
    output HLDA, READY,
    output EOP_N_in, tc,
    input  HRQ, AEN, ADSTB, DACK,
    input  MEMR_N, MEMW_N,
    input  IOR_N, IOW_N,
    input  upd, EOP_N_out,
    input  done, done_ch
  );

endinterface

// File: rtl/dma_timing_ctrl.sv
// DMA timing controller: SI/S0..S4/SW transfer FSM.
// Outputs are registered alongside the state they belong to.
module dma_timing_ctrl
  import DmaPackage::*;
(
  input logic CLK,
  input logic RESET,
  dma_timing_ctrl_if.master bus
);

  dmaState_t  state;
  logic [1:0] ch;
  xferType_t  xType;
  xferMode_t  xMode;
  logic       eopLat;
  busOut_t    out;
  logic [1:0] doneCh;
  logic       termNow;

  // Termination is decided on the edge into S4 so EOP/done line up with upd.
  assign termNow = bus.tc | eopLat | ~bus.EOP_N_in;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= SI;
      ch     <= 2'b00;
      xType  <= XferVerify;
      xMode  <= ModeSingle;
      eopLat <= 1'b0;
      out    <= IdleOut;
      doneCh <= 2'b00;
    end else begin
      out.upd   <= 1'b0;
      out.done  <= 1'b0;
      out.eopN  <= 1'b1;
      out.adstb <= 1'b0;
      unique case (state)
        SI: begin
          eopLat <= 1'b0;
          out    <= IdleOut;
          if (bus.req_valid) begin
            ch      <= bus.req_ch;
            xType   <= normType(bus.xfer_type);
            xMode   <= normMode(bus.xfer_mode);
            state   <= S0;
            out.hrq <= 1'b1;
          end
        end
        S0: begin
          if (bus.HLDA) begin
            state     <= S1;
            out.aen   <= 1'b1;
            out.adstb <= 1'b1;
          end
        end
        S1: begin
          if (!bus.HLDA) begin
            state <= SI;
            out   <= IdleOut;
          end else begin
            state    <= S2;
            out.dack <= chOneHot(ch);
            out.stb  <= rdStb(xType);
          end
        end
        S2: begin
          if (!bus.HLDA) begin
            state <= SI;
            out   <= IdleOut;
          end else begin
            eopLat  <= eopLat | ~bus.EOP_N_in;
            state   <= S3;
            out.stb <= rdStb(xType) & wrStb(xType);
          end
        end
        S3, SW: begin
          if (!bus.HLDA) begin
            state <= SI;
            out   <= IdleOut;
          end else if (!bus.READY) begin
            eopLat <= eopLat | ~bus.EOP_N_in;
            state  <= SW;
          end else begin
            state    <= S4;
            out.stb  <= StbIdle;
            out.upd  <= 1'b1;
            out.done <= termNow;
            out.eopN <= ~termNow;
            if (termNow) doneCh <= ch;
          end
        end
        S4: begin
          if (out.done) begin
            state <= SI;
            out   <= IdleOut;
          end else if (xMode == ModeBlock ||
                       (xMode == ModeDemand &&
                        bus.dreq_active)) begin
            state     <= S1;
            out.adstb <= 1'b1;
            out.dack  <= 4'b0000;
          end else begin
            state <= SI;
            out   <= IdleOut;
          end
        end
        default: begin
          state <= SI;
          out   <= IdleOut;
        end
      endcase
    end
  end

  assign bus.HRQ       = out.hrq;
  assign bus.AEN       = out.aen;
  assign bus.ADSTB     = out.adstb;
  assign bus.DACK      = out.dack;
  assign bus.MEMR_N    = out.stb.memrN;
  assign bus.MEMW_N    = out.stb.memwN;
  assign bus.IOR_N     = out.stb.iorN;
  assign bus.IOW_N     = out.stb.iowN;
  assign bus.upd       = out.upd;
  assign bus.EOP_N_out = out.eopN;
  assign bus.done      = out.done;
  assign bus.done_ch   = doneCh;

endmodule
